instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 128, giving the number of instruction memory words (word-indexed pc).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the number of fetched-instruction buffer entries.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock shared with the instruction memory.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  permits new fetch issues while high.
REQ-007 pc  output  32  word address presented to the instruction memory.
REQ-008 inst  input  32  memory read data, registered by the memory: valid in the cycle after pc is sampled.
REQ-009 inst_valid  output  1  buffer head holds a valid instruction.
REQ-010 inst_ready  input  1  decode accepts the head this cycle.
REQ-011 inst_out  output  32  instruction at the buffer head.
REQ-012 inst_pc  output  32  pc of inst_out.
REQ-013 redirect_valid  input  1  branch/jump redirect request (BEQ/BNE taken).
REQ-014 redirect_pc  input  32  redirect target word address.
REQ-015 fifo_count  output  3  current buffer occupancy, 0..FIFO_DEPTH.

Function
REQ-016 An issue SHALL occur at a clock edge when enable=1, redirect_valid=0 and (fifo_count + resp_pending) < FIFO_DEPTH; resp_pending is 1 when an issue occurred at the previous edge.
REQ-017 On issue, the memory samples the current pc and pc SHALL advance to pc+1, wrapping from IMEM_DEPTH-1 to 0.
REQ-018 When resp_pending=1, inst and the pc it was fetched from SHALL be pushed into the buffer at the next edge, unless redirect_valid=1.
REQ-019 Latency SHALL be two cycles: an issue at the end of cycle N gives inst_valid=1 in cycle N+2.
REQ-020 A pop SHALL occur when inst_valid=1 and inst_ready=1, and SHALL advance the head at that edge.
REQ-021 Simultaneous push and pop SHALL leave fifo_count unchanged and keep order.
REQ-022 The issue credit rule SHALL prevent overflow: no push is ever lost and fifo_count never exceeds FIFO_DEPTH.
REQ-023 With inst_ready held high, throughput SHALL be one instruction per cycle.
REQ-024 inst_valid SHALL be 0 when the buffer is empty; inst_out/inst_pc then hold their last values.
REQ-025 A redirect SHALL take priority over issue, push and pop at the same edge: the buffer is cleared, resp_pending is cleared and any response in flight is discarded.
REQ-026 On redirect, pc SHALL load redirect_pc modulo IMEM_DEPTH, with upper bits zero.
REQ-027 After a redirect in cycle C, the target SHALL be issued at the end of cycle C+1 (if enabled) and appear with inst_valid=1 in cycle C+3.
REQ-028 Deasserting enable SHALL stop new issues only; a pending response is still pushed.
REQ-029 The fetch control SHALL have three states, decided each cycle: RUN (issuing), STALL (credit exhausted or enable=0), FLUSH (redirect_valid=1).

Reset
REQ-030 On reset: pc=0, buffer empty, fifo_count=0, resp_pending=0, inst_valid=0, inst_out=0, inst_pc=0.
REQ-031 Reset SHALL override redirect and all handshakes, and SHALL discard any in-flight response.
REQ-032 The first issue SHALL be at the end of the first cycle with reset=0 and enable=1.

Structure
REQ-033 A shared package fetch_pkg SHALL hold IMEM_DEPTH, FIFO_DEPTH, PC_W=32, INST_W=32 and the fetch-state enum.
REQ-034 The buffer SHALL be a separate sub-module, fetch_fifo: synchronous FIFO storing {pc, inst} with push/pop/clear/count.

Verification
REQ-035 Reset, then enable=1 with inst_ready=1 and memory words 0..6 preloaded -> inst_pc sequence 0,1,2,... with inst_valid first high in cycle 2 and then every cycle.
REQ-036 inst_ready=0 for 10 cycles -> fifo_count saturates at 4, pc stops advancing, no instruction lost or duplicated after inst_ready=1.
REQ-037 redirect_valid=1 with redirect_pc=5 while the buffer holds 3 entries -> buffer cleared next cycle, the stale response is dropped, next delivered inst_pc=5 in cycle C+3.
REQ-038 Start at pc=126 -> delivered inst_pc sequence 126,127,0,1.
REQ-039 Redirect, pop and push in the same cycle -> redirect wins: fifo_count=0 after the edge, pc=redirect_pc.
REQ-040 reset asserted mid-stream with 2 entries buffered -> the next cycle shows all REQ-030 values, and the in-flight response is not pushed.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared sizing, fetch-state encoding and buffer entry layout for the
// instruction fetch unit.
package fetch_pkg;

  localparam int unsigned IMEM_DEPTH = 128;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PC_W       = 32;
  localparam int unsigned INST_W     = 32;

  typedef enum logic [1:0] {
    FS_RUN   = 2'd0,
    FS_STALL = 2'd1,
    FS_FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetched-instruction buffer: synchronous FIFO of {pc, inst} with a registered
// head that keeps its last value once the buffer drains or is cleared.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             push_i,
  input  fetch_entry_t     data_i,
  input  logic             pop_i,
  output fetch_entry_t     head_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] count_q, count_d;
  fetch_entry_t     head_q, head_d;
  logic             valid_q, valid_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  // Next head comes from the write port when the pushed entry lands on the new read slot.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    head_d  = head_q;
    if (clear_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (do_pop)  rd_d = ptr_inc(rd_q);
      if (do_push) wr_d = ptr_inc(wr_q);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      if (count_d != '0) begin
        head_d = (do_push && (wr_q == rd_d)) ? data_i : mem_q[rd_d];
      end
    end
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      head_q  <= head_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_q] <= data_i;
  end

  assign head_o  = head_q;
  assign valid_o = valid_q;
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: issues word addresses to a registered instruction memory
// under a buffer credit rule and queues responses for decode.
module instruction_fetch #(
  parameter int unsigned IMEM_DEPTH = fetch_pkg::IMEM_DEPTH,
  parameter int unsigned FIFO_DEPTH = fetch_pkg::FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  output logic [fetch_pkg::PC_W-1:0]   pc,
  input  logic [fetch_pkg::INST_W-1:0] inst,
  output logic                         inst_valid,
  input  logic                         inst_ready,
  output logic [fetch_pkg::INST_W-1:0] inst_out,
  output logic [fetch_pkg::PC_W-1:0]   inst_pc,
  input  logic                         redirect_valid,
  input  logic [fetch_pkg::PC_W-1:0]   redirect_pc,
  output logic [2:0]                   fifo_count
);

  import fetch_pkg::*;

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e    state_c;
  logic [PC_W-1:0] pc_q, resp_pc_q;
  logic            pend_q;
  logic [CNT_W-1:0] count_w;
  fetch_entry_t    head_w, push_data;
  logic            valid_w, push_c, pop_c;

  // Credit counts the buffered entries plus the response still in flight.
  always_comb begin
    state_c = FS_STALL;
    if (redirect_valid) begin
      state_c = FS_FLUSH;
    end else if (enable && ((32'(count_w) + 32'(pend_q)) < FIFO_DEPTH)) begin
      state_c = FS_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= '0;
      resp_pc_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      unique case (state_c)
        FS_FLUSH: begin
          pc_q   <= redirect_pc % PC_W'(IMEM_DEPTH);
          pend_q <= 1'b0;
        end
        FS_RUN: begin
          pc_q      <= (pc_q == PC_W'(IMEM_DEPTH - 1)) ? '0 : pc_q + PC_W'(1);
          resp_pc_q <= pc_q;
          pend_q    <= 1'b1;
        end
        default: pend_q <= 1'b0;
      endcase
    end
  end

  assign push_c    = pend_q && !redirect_valid;
  assign pop_c     = valid_w && inst_ready;
  assign push_data = '{pc: resp_pc_q, inst: inst};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear_i (redirect_valid),
    .push_i  (push_c),
    .data_i  (push_data),
    .pop_i   (pop_c),
    .head_o  (head_w),
    .valid_o (valid_w),
    .count_o (count_w)
  );

  assign pc         = pc_q;
  assign inst_valid = valid_w;
  assign inst_out   = head_w.inst;
  assign inst_pc    = head_w.pc;
  assign fifo_count = 3'(count_w);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed timing scenarios plus randomized traffic
// checked by a scoreboard that expects a consecutive pc stream per redirect/reset.
module tb_instruction_fetch;

  localparam int unsigned IMEM_D = 128;

  logic        clk = 1'b0;
  logic        reset, enable, inst_ready, redirect_valid;
  logic [31:0] redirect_pc, inst, pc, inst_out, inst_pc;
  logic        inst_valid;
  logic [2:0]  fifo_count;

  logic [31:0] imem [IMEM_D];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned pops     = 0;
  int unsigned last_pc  = 0;
  int unsigned exp_base = 0;
  int unsigned exp_q [$];

  instruction_fetch #(.IMEM_DEPTH(128), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .pc             (pc),
    .inst           (inst),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  // Registered instruction memory: data for the sampled pc appears next cycle.
  always @(posedge clk) inst <= imem[pc[6:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_max(input string name, input logic [31:0] act, input logic [31:0] max);
    n_checks++;
    if ((^act === 1'bx) || (act > max)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected at most %0d at %0t", name, act, max, $time);
    end
  endtask

  task automatic check_min(input string name, input logic [31:0] act, input logic [31:0] min);
    n_checks++;
    if ((^act === 1'bx) || (act < min)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected at least %0d at %0t", name, act, min, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, pc, 0);
    check({tag, "_count"}, 32'(fifo_count), 0);
    check({tag, "_valid"}, 32'(inst_valid), 0);
    check({tag, "_inst_out"}, inst_out, 0);
    check({tag, "_inst_pc"}, inst_pc, 0);
  endtask

  // Scoreboard monitor: the delivered stream is consecutive pcs (mod depth) from the last flush point.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp_base = 0;
    end else if (redirect_valid) begin
      exp_q.delete();
      exp_base = redirect_pc % IMEM_D;
    end else begin
      check_max("fifo_count_bound", 32'(fifo_count), 4);
      check_max("pc_range", pc, IMEM_D - 1);
      if (inst_valid && inst_ready) begin
        int unsigned e;
        while (exp_q.size() < 4) begin
          exp_q.push_back(exp_base);
          exp_base = (exp_base + 1) % IMEM_D;
        end
        e = exp_q.pop_front();
        check("pop_pc", inst_pc, e);
        check("pop_inst", inst_out, imem[e]);
        last_pc = e;
        pops++;
      end
    end
  end

  initial begin
    int unsigned seq38 [4];
    int unsigned pops_before;
    seq38[0] = 126; seq38[1] = 127; seq38[2] = 0; seq38[3] = 1;
    for (int i = 0; i < int'(IMEM_D); i++) imem[i] = $urandom;

    reset = 1'b1; enable = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) tick();
    check_reset_state("reset");

    // Streaming from reset: first valid in cycle 2, then one per cycle.
    reset = 1'b0; enable = 1'b1; inst_ready = 1'b1;
    check("c0_valid", 32'(inst_valid), 0);
    tick();
    check("c1_valid", 32'(inst_valid), 0);
    for (int k = 2; k <= 8; k++) begin
      tick();
      check("stream_valid", 32'(inst_valid), 1);
      check("stream_pc", inst_pc, 32'(k - 2));
    end

    // Build 3 buffered entries plus one in flight, then redirect with a pop attempt.
    inst_ready = 1'b0;
    tick(); tick();
    check("pre_redirect_count", 32'(fifo_count), 3);
    redirect_valid = 1'b1; redirect_pc = 32'd5; inst_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("redir_count", 32'(fifo_count), 0);
    check("redir_valid", 32'(inst_valid), 0);
    check("redir_pc", pc, 5);
    tick();
    check("redir_c2_valid", 32'(inst_valid), 0);
    tick();
    check("redir_c3_valid", 32'(inst_valid), 1);
    check("redir_c3_pc", inst_pc, 5);

    // Backpressure: buffer saturates at 4 and pc stops issuing.
    repeat (5) tick();
    inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_max("stall_count", 32'(fifo_count), 4);
    end
    check("stall_full", 32'(fifo_count), 4);
    check("stall_pc", pc, 14);
    check("stall_head", inst_pc, 10);
    inst_ready = 1'b1;
    repeat (10) tick();

    // Wrap at the top of instruction memory.
    redirect_valid = 1'b1; redirect_pc = 32'd126;
    tick();
    redirect_valid = 1'b0;
    check("wrap_pc_load", pc, 126);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wrap_valid", 32'(inst_valid), 1);
      check("wrap_seq", inst_pc, seq38[i]);
    end

    // Mid-stream reset with 2 buffered entries, in-flight response and a competing redirect.
    inst_ready = 1'b0;
    tick();
    check("prereset_count", 32'(fifo_count), 2);
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd50; inst_ready = 1'b1;
    tick();
    check_reset_state("midreset");
    reset = 1'b0; redirect_valid = 1'b0;
    tick();
    check("postreset_count", 32'(fifo_count), 0);
    check("postreset_valid", 32'(inst_valid), 0);
    tick();
    check("postreset_first_valid", 32'(inst_valid), 1);
    check("postreset_first_pc", inst_pc, 0);

    // Randomized traffic against the scoreboard.
    pops_before = pops;
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset          = ($urandom_range(0, 299) == 0);
      enable         = ($urandom_range(0, 9) < 8);
      inst_ready     = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc    = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 127));
    end
    tick();
    reset = 1'b0; redirect_valid = 1'b0; enable = 1'b1; inst_ready = 1'b1;
    repeat (10) tick();
    enable = 1'b0;
    repeat (8) tick();
    check_min("random_progress", pops - pops_before, 300);
    check("drain_count", 32'(fifo_count), 0);
    check("drain_valid", 32'(inst_valid), 0);
    check("hold_inst_pc", inst_pc, last_pc);
    check("hold_inst_out", inst_out, imem[last_pc]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
